system_0_cpu_0_mul_seq: RTL and testbench
=========================================

// Module: system_0_cpu_0_mul_seq
// PURPOSE
//  Multi-cycle multiply sequencer feeding system_0_cpu_0_mult_cell (16x16 partial-product cell).
//  Accepts 32x32 multiply requests (valid/ready), drives four zero-extended 16x16 passes into the cell
//  and accumulates a 64-bit product. Returns MUL low word or MULXUU/MULXSS/MULXSU high word via a
//  valid/ready response port to the CPU writeback stage.
// PARAMETERS
//  CELL_LATENCY  1  cycles from cell_src1/2 change to matching cell_result (legal 1..3)
//  SIGNED_OPS    1  1: MULXSS/MULXSU apply signed correction; 0: op 2'b10/2'b11 behave as MULXUU
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   sequencer idle, request accepted when req_valid&&req_ready
//  req_op       in   2   00 MUL(low), 01 MULXUU, 10 MULXSS, 11 MULXSU (high words)
//  req_src1     in   32  operand A (rA)
//  req_src2     in   32  operand B (rB)
//  cell_src1    out  32  to cell A_mul_src1: {16'h0, A half} per pass
//  cell_src2    out  32  to cell A_mul_src2: {16'h0, B half} per pass
//  cell_result  in   32  from cell A_mul_cell_result (full 16x16 product, zero-extended operands)
//  rsp_valid    out  1   result available
//  rsp_ready    in   1   consumer takes result when rsp_valid&&rsp_ready
//  rsp_result   out  32  selected product word
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE; req_ready=0, rsp_valid=0, rsp_result=0, cell_src1/2=0, acc=0,
//    pass pipeline cleared. req_ready=1 the first cycle after reset deasserts. Reset mid-op aborts, no rsp.
//  - States: IDLE -> ISSUE -> DRAIN -> FIX -> RESP -> IDLE. No overlap: req_ready=1 only in IDLE.
//  - Accept at cycle A: latch src1, src2, op; req_ready=0 from A+1. acc cleared.
//  - ISSUE: passes driven A+1..A+N; order LL(aL*bL), LH(aL*bH), HL(aH*bL), HH(aH*bH).
//    N=3 for MUL (HH skipped), N=4 for high ops. cell_src = 0 outside ISSUE.
//  - Pass tag (index) shifted through CELL_LATENCY-deep valid pipe; result of pass i sampled at end of
//    cycle A+1+i+CELL_LATENCY. acc += LL<<0, LH<<16, HL<<16, HH<<32 (64-bit, mod 2^64).
//  - DRAIN: waits until last pass tag retires. FIX (one cycle): hi=acc[63:32];
//    MULXSS: hi -= (a[31]?b:0) + (b[31]?a:0); MULXSU: hi -= (a[31]?b:0); all mod 2^32.
//    rsp_result <= (op==MUL) ? acc[31:0] : hi.
//  - rsp_valid rises at cycle A+2+N+CELL_LATENCY (MUL A+6, high ops A+7 at latency 1).
//  - RESP: rsp_valid and rsp_result held stable until rsp_valid&&rsp_ready; on that edge rsp_valid=0,
//    state=IDLE, req_ready=1 next cycle. rsp_result keeps last value after handshake.
//  - req_valid while busy ignored (not latched); operand changes after accept have no effect.
//  - rsp_ready high before rsp_valid has no effect; simultaneous req_valid in RESP not accepted.
// TESTING
//  1. MUL 0x0001_0003 * 0x0002_0005, rsp_ready=1 -> rsp_result 0x000B_000F, rsp_valid at A+6 for 1 cycle.
//  2. MULXUU 0xFFFF_FFFF * 0xFFFF_FFFF -> 0xFFFF_FFFE at A+7; cell_src sequence LL,LH,HL,HH checked.
//  3. MULXSS -1*2 -> 0xFFFF_FFFF; MULXSU -1*2 -> 0xFFFF_FFFF; MULXSS 0x8000_0000^2 -> 0x4000_0000.
//  4. rsp_ready=0 for 5 cycles -> rsp_valid/rsp_result stable, req_ready=0; release -> req_ready=1 next cycle.
//  5. reset pulsed at A+3 -> rsp_valid never rises, outputs 0, req_ready=1 cycle after reset drops.
//  6. CELL_LATENCY=2, repeat test 2 -> 0xFFFF_FFFE at A+8; back-to-back requests give correct results.

Source files
------------

// File: rtl/system_0_cpu_0_mul_seq.sv
// Sequences a 32x32 multiply as four 16x16 passes through an external partial-product
// cell, accumulates the 64-bit product and returns the low or (signed-corrected) high word.
module system_0_cpu_0_mul_seq #(
   parameter int CELL_LATENCY = 1,
   parameter bit SIGNED_OPS   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   input  logic [31:0] cell_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_FIX   = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  pass_q, pass_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] cell_src1_q, cell_src1_d, cell_src2_q, cell_src2_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic        req_ready_q, req_ready_d;

   logic                    issue_vld;
   logic [1:0]              issue_tag;
   logic [CELL_LATENCY-1:0] pv_q;
   logic [1:0]              pt_q [CELL_LATENCY];
   logic                    ret_vld;
   logic [1:0]              ret_tag;
   logic [1:0]              last_idx;
   logic [5:0]              shamt;
   logic [31:0]             hi;

   // Pass p uses A high half when p[1] is set and B high half when p[0] is set.
   function automatic logic [31:0] a_half(input logic [31:0] v, input logic [1:0] p);
      return {16'h0, (p[1] ? v[31:16] : v[15:0])};
   endfunction

   function automatic logic [31:0] b_half(input logic [31:0] v, input logic [1:0] p);
      return {16'h0, (p[0] ? v[31:16] : v[15:0])};
   endfunction

   assign ret_vld  = pv_q[CELL_LATENCY-1];
   assign ret_tag  = pt_q[CELL_LATENCY-1];
   assign last_idx = (op_q == 2'b00) ? 2'd2 : 2'd3;
   assign shamt    = (ret_tag == 2'd0) ? 6'd0 : ((ret_tag == 2'd3) ? 6'd32 : 6'd16);

   always_comb begin
      hi = acc_q[63:32];
      if (SIGNED_OPS && op_q == 2'b10)
         hi = hi - (a_q[31] ? b_q : 32'h0) - (b_q[31] ? a_q : 32'h0);
      else if (SIGNED_OPS && op_q == 2'b11)
         hi = hi - (a_q[31] ? b_q : 32'h0);
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      pass_d       = pass_q;
      acc_d        = acc_q;
      cell_src1_d  = cell_src1_q;
      cell_src2_d  = cell_src2_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      issue_vld    = 1'b0;
      issue_tag    = pass_q;
      if (ret_vld)
         acc_d = acc_q + ({32'h0, cell_result} << shamt);
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               a_d         = req_src1;
               b_d         = req_src2;
               op_d        = req_op;
               acc_d       = 64'h0;
               pass_d      = 2'd0;
               cell_src1_d = a_half(req_src1, 2'd0);
               cell_src2_d = b_half(req_src2, 2'd0);
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue_vld = 1'b1;
            if (pass_q == last_idx) begin
               cell_src1_d = 32'h0;
               cell_src2_d = 32'h0;
               state_d     = S_DRAIN;
            end else begin
               pass_d      = pass_q + 2'd1;
               cell_src1_d = a_half(a_q, pass_q + 2'd1);
               cell_src2_d = b_half(b_q, pass_q + 2'd1);
            end
         end
         S_DRAIN: begin
            if (ret_vld && ret_tag == last_idx)
               state_d = S_FIX;
         end
         S_FIX: begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = (op_q == 2'b00) ? acc_q[31:0] : hi;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         a_q          <= 32'h0;
         b_q          <= 32'h0;
         op_q         <= 2'b00;
         pass_q       <= 2'd0;
         acc_q        <= 64'h0;
         cell_src1_q  <= 32'h0;
         cell_src2_q  <= 32'h0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 32'h0;
         req_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         pass_q       <= pass_d;
         acc_q        <= acc_d;
         cell_src1_q  <= cell_src1_d;
         cell_src2_q  <= cell_src2_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         req_ready_q  <= req_ready_d;
      end
   end

   // Pass tags travel alongside the cell so each result is added with its own shift.
   genvar gi;
   generate
      for (gi = 0; gi < CELL_LATENCY; gi++) begin : g_pipe
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (reset) begin
                  pv_q[0] <= 1'b0;
                  pt_q[0] <= 2'd0;
               end else begin
                  pv_q[0] <= issue_vld;
                  pt_q[0] <= issue_tag;
               end
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (reset) begin
                  pv_q[gi] <= 1'b0;
                  pt_q[gi] <= 2'd0;
               end else begin
                  pv_q[gi] <= pv_q[gi-1];
                  pt_q[gi] <= pt_q[gi-1];
               end
            end
         end
      end
   endgenerate

   assign req_ready  = req_ready_q;
   assign cell_src1  = cell_src1_q;
   assign cell_src2  = cell_src2_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_system_0_cpu_0_mul_seq.sv
// Bench: two sequencers (cell latency 1 and 2), each with a behavioural 16x16 cell,
// driven from a vector table plus hand-written hold and reset sequences.
module tb_system_0_cpu_0_mul_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic [1:0]  req_op     [2];
   logic [31:0] req_src1   [2];
   logic [31:0] req_src2   [2];
   logic [31:0] cell_src1  [2];
   logic [31:0] cell_src2  [2];
   logic [31:0] cell_result[2];
   logic        rsp_valid  [2];
   logic        rsp_ready  [2];
   logic [31:0] rsp_result [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   system_0_cpu_0_mul_seq #(.CELL_LATENCY(1), .SIGNED_OPS(1'b1)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
      .req_src1(req_src1[0]), .req_src2(req_src2[0]),
      .cell_src1(cell_src1[0]), .cell_src2(cell_src2[0]), .cell_result(cell_result[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0])
   );

   system_0_cpu_0_mul_seq #(.CELL_LATENCY(2), .SIGNED_OPS(1'b1)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
      .req_src1(req_src1[1]), .req_src2(req_src2[1]),
      .cell_src1(cell_src1[1]), .cell_src2(cell_src2[1]), .cell_result(cell_result[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1])
   );

   // Behavioural cells: one and two register stages.
   logic [31:0] c0_q, c1a_q, c1b_q;
   always_ff @(posedge clk) begin
      c0_q  <= cell_src1[0] * cell_src2[0];
      c1a_q <= cell_src1[1] * cell_src2[1];
      c1b_q <= c1a_q;
   end
   assign cell_result[0] = c0_q;
   assign cell_result[1] = c1b_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request on instance i and checks pass order, latency and result.
   task automatic run_req(input int i, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      int lat, n, c, w;
      logic [1:0] p;
      lat = (i == 0) ? 1 : 2;
      n   = (op == 2'b00) ? 3 : 4;
      w   = 0;
      while (!req_ready[i] && w < 20) begin
         tick();
         w++;
      end
      chk("ready_wait", {31'h0, req_ready[i]}, 32'h1);
      req_valid[i] = 1'b1;
      req_op[i]    = op;
      req_src1[i]  = a;
      req_src2[i]  = b;
      tick();
      req_valid[i] = 1'b0;
      req_op[i]    = ~op;
      req_src1[i]  = ~a;
      req_src2[i]  = ~b;
      c = 1;
      chk("busy_ready", {31'h0, req_ready[i]}, 32'h0);
      while (!rsp_valid[i] && c < 40) begin
         if (c <= n) begin
            p = 2'(c - 1);
            chk("cell_a", cell_src1[i], {16'h0, (p[1] ? a[31:16] : a[15:0])});
            chk("cell_b", cell_src2[i], {16'h0, (p[0] ? b[31:16] : b[15:0])});
         end else if (c == n + 1) begin
            chk("cell_idle", cell_src1[i] | cell_src2[i], 32'h0);
         end
         tick();
         c++;
      end
      chk("rsp_latency", 32'(c), 32'(2 + n + lat));
      chk("rsp_result", rsp_result[i], exp);
      $display("inst=%0d op=%0d a=%h b=%h result=%h exp=%h cycles=%0d",
               i, op, a, b, rsp_result[i], exp, c);
      if (rsp_ready[i]) begin
         tick();
         chk("rsp_drop", {31'h0, rsp_valid[i]}, 32'h0);
         chk("ready_back", {31'h0, req_ready[i]}, 32'h1);
         chk("rsp_keep", rsp_result[i], exp);
      end
   endtask

   typedef struct {
      int          inst;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int hi_cnt;
      logic [31:0] held;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0;
         req_op[k]    = 2'b00;
         req_src1[k]  = 32'h0;
         req_src2[k]  = 32'h0;
         rsp_ready[k] = 1'b1;
      end
      vecs[0]  = '{0, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
      vecs[1]  = '{0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[2]  = '{0, 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[3]  = '{0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[4]  = '{0, 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[5]  = '{0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[6]  = '{0, 2'b11, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[7]  = '{0, 2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[8]  = '{0, 2'b00, 32'h0002_0001, 32'h0001_0003, 32'h0007_0003};
      vecs[9]  = '{1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[10] = '{1, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
      vecs[11] = '{1, 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[12] = '{1, 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};

      // Reset state
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready", {31'h0, req_ready[k]}, 32'h0);
         chk("rst_valid", {31'h0, rsp_valid[k]}, 32'h0);
         chk("rst_result", rsp_result[k], 32'h0);
         chk("rst_cell", cell_src1[k] | cell_src2[k], 32'h0);
      end
      reset = 1'b0;
      tick();
      chk("post_rst_ready0", {31'h0, req_ready[0]}, 32'h1);
      chk("post_rst_ready1", {31'h0, req_ready[1]}, 32'h1);

      for (int v = 0; v < 13; v++)
         run_req(vecs[v].inst, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp);

      // Back-pressure: result held while rsp_ready is low; a request in RESP is ignored.
      rsp_ready[0] = 1'b0;
      run_req(0, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
      held = rsp_result[0];
      req_valid[0] = 1'b1;
      req_op[0]    = 2'b01;
      req_src1[0]  = 32'h1234_5678;
      req_src2[0]  = 32'h9ABC_DEF0;
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", {31'h0, rsp_valid[0]}, 32'h1);
         chk("hold_result", rsp_result[0], held);
         chk("hold_ready", {31'h0, req_ready[0]}, 32'h0);
         $display("hold cycle=%0d rsp_valid=%0d result=%h", k, rsp_valid[0], rsp_result[0]);
         tick();
      end
      rsp_ready[0] = 1'b1;
      tick();
      chk("release_valid", {31'h0, rsp_valid[0]}, 32'h0);
      chk("release_ready", {31'h0, req_ready[0]}, 32'h1);
      req_valid[0] = 1'b0;
      tick();
      chk("resp_req_ignored", {31'h0, req_ready[0]}, 32'h1);
      chk("resp_req_cell", cell_src1[0] | cell_src2[0], 32'h0);

      // Reset at A+3 aborts the operation.
      req_valid[0] = 1'b1;
      req_op[0]    = 2'b01;
      req_src1[0]  = 32'hFFFF_FFFF;
      req_src2[0]  = 32'hFFFF_FFFF;
      tick();
      req_valid[0] = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_valid", {31'h0, rsp_valid[0]}, 32'h0);
      chk("abort_result", rsp_result[0], 32'h0);
      chk("abort_cell", cell_src1[0] | cell_src2[0], 32'h0);
      chk("abort_ready", {31'h0, req_ready[0]}, 32'h0);
      tick();
      chk("abort_ready_back", {31'h0, req_ready[0]}, 32'h1);
      hi_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (rsp_valid[0]) hi_cnt++;
         tick();
      end
      chk("abort_no_rsp", 32'(hi_cnt), 32'h0);
      $display("reset abort: rsp_valid cycles=%0d", hi_cnt);
      run_req(0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
      run_req(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
